// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared branch codes, BHT counter type and constants
//
// Purpose: types and constants shared by the branch resolution stage and its
// compare sub-module.
package branch_resolve_unit_pkg;

    // Shared branch condition encodings; code 3'd7 is undefined (not taken).
    typedef enum logic [2:0] {
        BNONE = 3'd0,
        BEQ   = 3'd1,
        BNE   = 3'd2,
        BLT   = 3'd3,
        BGE   = 3'd4,
        BLTU  = 3'd5,
        BGEU  = 3'd6
    } br_ctrl_e;

    // 2-bit saturating branch history counter; MSB is the predicted direction.
    typedef logic [1:0] bht_cnt_t;

    // Weakly not-taken.
    localparam bht_cnt_t BHT_RESET = 2'b01;

    // Instruction size used for the fall-through PC.
    localparam int INSN_ALIGN = 4;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - EX-stage branch request, result and BHT lookup bundle
//
// Purpose: groups the EX-stage op, the registered resolution, the performance
// counters and the IF-stage lookup port.
// Ports (master = pipeline side, slave = branch_resolve_unit):
//   valid_i, branctrl_i, rs1_i, rs2_i, pc_i, target_i, pred_taken_i,
//   stall_i, flush_i, lookup_pc_i          : master -> slave
//   lookup_taken_o, res_valid_o, taken_o, mispredict_o, redirect_pc_o,
//   branch_cnt_o, mispredict_cnt_o         : slave -> master
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic              valid_i;
    logic [2:0]        branctrl_i;
    logic [XLEN-1:0]   rs1_i;
    logic [XLEN-1:0]   rs2_i;
    logic [XLEN-1:0]   pc_i;
    logic [XLEN-1:0]   target_i;
    logic              pred_taken_i;
    logic              stall_i;
    logic              flush_i;
    logic [XLEN-1:0]   lookup_pc_i;
    logic              lookup_taken_o;
    logic              res_valid_o;
    logic              taken_o;
    logic              mispredict_o;
    logic [XLEN-1:0]   redirect_pc_o;
    logic [CNT_W-1:0]  branch_cnt_o;
    logic [CNT_W-1:0]  mispredict_cnt_o;

    modport master (
        output valid_i, branctrl_i, rs1_i, rs2_i, pc_i, target_i, pred_taken_i,
               stall_i, flush_i, lookup_pc_i,
        input  lookup_taken_o, res_valid_o, taken_o, mispredict_o, redirect_pc_o,
               branch_cnt_o, mispredict_cnt_o
    );

    modport slave (
        input  valid_i, branctrl_i, rs1_i, rs2_i, pc_i, target_i, pred_taken_i,
               stall_i, flush_i, lookup_pc_i,
        output lookup_taken_o, res_valid_o, taken_o, mispredict_o, redirect_pc_o,
               branch_cnt_o, mispredict_cnt_o
    );
endinterface

// File: rtl/branch_resolve_unit_compare.sv
// rtl/branch_resolve_unit_compare.sv - combinational branch condition evaluation
//
// Purpose: maps a branch condition code and two operands to the taken flag.
// Ports:
//   i_branctrl  3     condition code (br_ctrl_e encoding)
//   i_rs1/i_rs2 XLEN  operands
//   o_taken     1     condition result; BNONE and undefined codes give 0
module branch_compare
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_branctrl,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_taken
);
    logic w_eq;
    logic w_lt_s;
    logic w_lt_u;

    assign w_eq   = (i_rs1 == i_rs2);
    assign w_lt_s = ($signed(i_rs1) < $signed(i_rs2));
    assign w_lt_u = (i_rs1 < i_rs2);

    always_comb begin
        o_taken = 1'b0;
        case (i_branctrl)
            BEQ:     o_taken = w_eq;
            BNE:     o_taken = !w_eq;
            BLT:     o_taken = w_lt_s;
            BGE:     o_taken = !w_lt_s;
            BLTU:    o_taken = w_lt_u;
            BGEU:    o_taken = !w_lt_u;
            default: o_taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX/MEM branch resolution with BHT and perf counters
//
// Purpose: resolves the branch in EX, registers direction / mispredict /
// redirect PC, trains a direct-mapped table of 2-bit counters read by IF, and
// counts accepted branches and mispredicts.
// Ports:
//   clk    1  clock
//   rst_n  1  asynchronous active-low reset
//   bus    branch_resolve_unit_if.slave (op inputs, results, lookup, counters)
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_unit_if.slave  bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0]  w_upd_idx;
    logic [IDX_W-1:0]  w_lookup_idx;
    logic              w_taken;
    logic              w_accept;
    logic              w_mispredict;
    logic [XLEN-1:0]   w_next_pc;
    logic              w_unused_pc_bits;

    bht_cnt_t          r_bht [BHT_ENTRIES];
    logic              r_res_valid;
    logic              r_taken;
    logic              r_mispredict;
    logic [XLEN-1:0]   r_redirect_pc;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_mispredict_cnt;

    branch_compare #(.XLEN(XLEN)) u_compare (
        .i_branctrl (bus.branctrl_i),
        .i_rs1      (bus.rs1_i),
        .i_rs2      (bus.rs2_i),
        .o_taken    (w_taken)
    );

    // Word-aligned PCs: index starts at bit 2.
    assign w_upd_idx        = bus.pc_i[IDX_W+1:2];
    assign w_lookup_idx     = bus.lookup_pc_i[IDX_W+1:2];
    assign w_unused_pc_bits = ^{bus.lookup_pc_i[XLEN-1:IDX_W+2], bus.lookup_pc_i[1:0]};

    assign w_accept     = bus.valid_i && !bus.stall_i && !bus.flush_i &&
                          (bus.branctrl_i != BNONE);
    assign w_mispredict = w_taken ^ bus.pred_taken_i;
    assign w_next_pc    = w_taken ? bus.target_i : (bus.pc_i + XLEN'(INSN_ALIGN));

    // Reads the registered table only, so a same-cycle update is not bypassed.
    assign bus.lookup_taken_o = r_bht[w_lookup_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= BHT_RESET;
            end
        end else if (w_accept) begin
            if (w_taken && r_bht[w_upd_idx] != 2'b11) begin
                r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'b01;
            end else if (!w_taken && r_bht[w_upd_idx] != 2'b00) begin
                r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'b01;
            end
        end
    end

    // Flush clears the valid/mispredict pair even while stalled; a plain
    // stall freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid   <= 1'b0;
            r_taken       <= 1'b0;
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
        end else if (bus.flush_i) begin
            r_res_valid   <= 1'b0;
            r_mispredict  <= 1'b0;
        end else if (!bus.stall_i) begin
            if (w_accept) begin
                r_res_valid   <= 1'b1;
                r_taken       <= w_taken;
                r_mispredict  <= w_mispredict;
                r_redirect_pc <= w_next_pc;
            end else begin
                r_res_valid   <= 1'b0;
                r_mispredict  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (w_accept) begin
            r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_mispredict) begin
                r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
            end
        end
    end

    assign bus.res_valid_o      = r_res_valid;
    assign bus.taken_o          = r_taken;
    assign bus.mispredict_o     = r_mispredict;
    assign bus.redirect_pc_o    = r_redirect_pc;
    assign bus.branch_cnt_o     = r_branch_cnt;
    assign bus.mispredict_cnt_o = r_mispredict_cnt;
endmodule
